// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA scan path:
//   - default 640x480@60 timing (active / porch / sync lengths per axis)
//   - derived totals and sync window bounds
//   - phase_t: the four phases each scan axis steps through
//   - BAR_TABLE: colour-bar test pattern, indexed by x[9:7]
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Scan phase of one axis: visible, front porch, sync pulse, back porch.
  typedef enum logic [1:0] {ACT, FP, SYN, BPO} phase_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red,
  // blue, black.
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/vga_scan_driver_if.sv
// -----------------------------------------------------------------------------
// vga_scan_driver_if
//   Renderer bus between the scan driver and the pixel renderers.
//   master (scan driver): drives x, y, active; samples pix_r/g/b/a.
//   slave  (renderer)   : reads x, y, active; returns pix_r/g/b/a
//                         combinationally for the current coordinate.
// -----------------------------------------------------------------------------
interface vga_scan_driver_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_a;

  modport master (output x, y, active, input pix_r, pix_g, pix_b, pix_a);
  modport slave  (input x, y, active, output pix_r, pix_g, pix_b, pix_a);
endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One scan axis: a 10-bit counter 0..TOTAL-1 plus a phase FSM that tracks
//   ACT -> FP -> SYN -> BPO in lock-step with the count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ce         : pixel clock enable; nothing moves while low
//   inc        : advance request (1 for horizontal, h wrap for vertical)
//   cnt        : current count
//   phase      : current phase
//   wrap       : inc is set and cnt is at TOTAL-1 (next advance returns to 0)
//   in_sync    : phase is SYN
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int unsigned FP_LEN     = DEF_H_FP,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter int unsigned BP_LEN     = DEF_H_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       inc,
  output logic [9:0] cnt,
  output phase_t     phase,
  output logic       wrap,
  output logic       in_sync
);

  localparam int unsigned TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  if (TOTAL > 1024) begin : g_total_check
    $error("vga_axis_counter: TOTAL=%0d exceeds the 10-bit counter range", TOTAL);
  end

  localparam logic [9:0] LAST     = 10'(TOTAL - 1);
  localparam logic [9:0] ACT_LAST = 10'(ACTIVE_LEN - 1);
  localparam logic [9:0] FP_LAST  = 10'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [9:0] SYN_LAST = 10'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);

  phase_t phase_q;
  phase_t phase_next;
  logic   at_last;

  assign at_last = (cnt == LAST);
  assign wrap    = inc && at_last;
  assign phase   = phase_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ce && inc) begin
      cnt <= at_last ? '0 : cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= ACT;
    end else if (ce && inc) begin
      phase_q <= phase_next;
    end
  end

  // Transition on the last count of each phase. Checked from the end of the
  // line backwards so a zero-length porch collapses into the following phase.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    phase_next = phase_q;
    if (at_last)                phase_next = ACT;
    else if (cnt == SYN_LAST)   phase_next = BPO;
    else if (cnt == FP_LAST)    phase_next = SYN;
    else if (cnt == ACT_LAST)   phase_next = FP;
  end

  always_comb begin
    in_sync = (phase_q == SYN);
  end

endmodule

// File: rtl/vga_scan_driver.sv
// -----------------------------------------------------------------------------
// vga_scan_driver
//   Pixel-scan master: generates x/y for the renderers, registers the returned
//   colour together with HSYNC/VSYNC/DE (one pixel of latency, all aligned),
//   and provides frame strobes for game logic.
// Optional feature: define VGA_TEST_PATTERN_EN to add input test_mode, which
//   replaces active pixels with 8 vertical colour bars selected by x[9:7].
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pix_ce          : pixel clock enable; low freezes all state
//   test_mode       : (VGA_TEST_PATTERN_EN only) colour-bar override
//   pix             : renderer bus (x, y, active out; pix_r/g/b/a in)
//   vga_r/g/b       : registered colour to the DAC
//   vga_hs, vga_vs  : registered syncs, asserted level SYNC_POL
//   vga_de          : registered data enable
//   frame_start     : one-clk pulse after the (h,v) -> (0,0) wrap
//   vblank          : y >= V_ACTIVE
//   frame_cnt       : completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_ce,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                test_mode,
`endif
  vga_scan_driver_if.master   pix,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic                frame_start,
  output logic                vblank,
  output logic [15:0]         frame_cnt
);

  logic [9:0]  h_cnt, v_cnt;
  phase_t      h_phase, v_phase;
  logic        h_wrap, v_wrap, h_in_sync, v_in_sync;
  logic        active;
  logic        frame_wrap;
  logic [23:0] pix_color;
  logic [15:0] frame_cnt_q;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE), .FP_LEN (H_FP), .SYNC_LEN (H_SYNC), .BP_LEN (H_BP)
  ) u_h_axis (
    .clk (clk), .rst_n (rst_n), .ce (pix_ce), .inc (1'b1),
    .cnt (h_cnt), .phase (h_phase), .wrap (h_wrap), .in_sync (h_in_sync)
  );

  // The vertical axis steps once per line, on the edge where h wraps.
  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE), .FP_LEN (V_FP), .SYNC_LEN (V_SYNC), .BP_LEN (V_BP)
  ) u_v_axis (
    .clk (clk), .rst_n (rst_n), .ce (pix_ce), .inc (h_wrap),
    .cnt (v_cnt), .phase (v_phase), .wrap (v_wrap), .in_sync (v_in_sync)
  );

  // Phase ACT is exactly count < ACTIVE on each axis.
  assign active     = (h_phase == ACT) && (v_phase == ACT);
  assign vblank     = (v_phase != ACT);
  assign frame_wrap = h_wrap && v_wrap;
  assign frame_cnt  = frame_cnt_q;

  assign pix.x      = h_cnt;
  assign pix.y      = v_cnt;
  assign pix.active = active;

  // Blanking is always black; transparent active pixels show the background.
  always_comb begin
    pix_color = 24'h000000;
    if (active) begin
      pix_color = pix.pix_a ? {pix.pix_r, pix.pix_g, pix.pix_b} : BG_COLOR;
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) pix_color = BAR_TABLE[h_cnt[9:7]];
`endif
    end
  end

  // Colour, DE and syncs are registered from the same counter state, so they
  // stay aligned with one pixel of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_de      <= 1'b0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      frame_start <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      // Pulse lasts one clk even when pix_ce is sparse.
      frame_start <= pix_ce && frame_wrap;
      if (pix_ce) begin
        {vga_r, vga_g, vga_b} <= pix_color;
        vga_de <= active;
        vga_hs <= h_in_sync ? SYNC_POL : ~SYNC_POL;
        vga_vs <= v_in_sync ? SYNC_POL : ~SYNC_POL;
        if (frame_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Pixel-scan master for the VGA output path.
- Generates the x/y coordinates consumed by all renderers (playfield, gameover screen, sprites), samples the composited R/G/B/A they return, and drives registered, sync-aligned colour and HSYNC/VSYNC to the DAC/connector.
- Also provides frame-timing strobes (frame_start, vblank, frame_cnt) so game logic updates state only during blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of vga_hs/vga_vs (0 = active-low)
- BG_COLOR, 24'h000000, colour driven for active pixels whose pix_a=0

Ports:
- clk  in  1  system clock (single clock domain)
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable (1-in-2 at 50 MHz for 25 MHz pixel rate)
- x  out  10  current horizontal counter, to renderers
- y  out  10  current vertical counter, to renderers
- active  out  1  x<H_ACTIVE and y<V_ACTIVE (combinational from counters)
- pix_r / pix_g / pix_b  in  8 each  renderer colour for current x,y (combinational path)
- pix_a  in  1  renderer alpha: 1 = opaque, 0 = transparent
- vga_r / vga_g / vga_b  out  8 each  registered colour to DAC
- vga_hs / vga_vs  out  1 each  registered syncs
- vga_de  out  1  registered data-enable, aligned with colour
- frame_start  out  1  one-clk pulse at frame wrap
- vblank  out  1  y>=V_ACTIVE
- frame_cnt  out  16  completed-frame count

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All flops reset asynchronously on rst_n=0.
- Counters:
  - h_cnt 0..H_TOTAL-1 (800); v_cnt 0..V_TOTAL-1 (525).
  - Both advance only on clk edges with pix_ce=1. pix_ce=0 freezes all state, including output registers.
  - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt. v_cnt wraps V_TOTAL-1 -> 0 on the same edge that h wraps.
  - x=h_cnt and y=v_cnt always; renderers handle out-of-range coordinates themselves.
- Horizontal phase FSM (derived from h_cnt, encoded in the package):
  - H_ACT [0,640) -> H_FP [640,656) -> H_SYN [656,752) -> H_BPO [752,800) -> back to H_ACT.
  - Vertical uses the same scheme on v_cnt with V_* values.
- Output stage, one-pixel latency: on a pix_ce edge, register the values for the current counters:
  - vga_de <= active
  - colour <= active ? (pix_a ? {pix_r,pix_g,pix_b} : BG_COLOR) : 24'h0. Blanking is always black.
  - vga_hs <= SYNC_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~SYNC_POL.
  - vga_vs is defined the same way on v_cnt. Syncs share the colour pipeline delay, so all remain aligned.
- frame_start:
  - High for exactly one clk, on the clk following the pix_ce edge where (h,v) wraps to (0,0).
  - Not asserted when leaving reset.
- frame_cnt increments on that same wrap edge; it wraps 16'hFFFF -> 0.
- vblank is combinational from v_cnt and covers the full lines V_ACTIVE..V_TOTAL-1.
- Reset values:
  - h_cnt=0, v_cnt=0, frame_cnt=0.
  - vga_r/g/b=0, vga_de=0, frame_start=0.
  - vga_hs=vga_vs=~SYNC_POL (deasserted).
- Reset mid-frame: counters return to (0,0) immediately and asynchronously. The first pix_ce after release outputs pixel (0,0).
- Width rule: all compare constants are 10-bit. Parameters must satisfy H_TOTAL, V_TOTAL <= 1024 (checked by an elaboration assertion).

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: adds input test_mode. When test_mode=1, the active-pixel colour is replaced by 8 vertical colour bars, x[9:7] indexing {white, yellow, cyan, green, magenta, red, blue, black}. pix_* inputs are ignored; timing is unchanged.
- Undefined: port absent; colour comes only from pix_*/BG_COLOR.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing localparams and derived H_TOTAL/V_TOTAL/sync start/end
  - the phase enum (ACT, FP, SYN, BPO)
  - the test-bar colour table
- One sub-module, vga_axis_counter: a parameterised counter plus phase decode, with inputs ce and inc and outputs wrap and in_sync. Instantiated twice, horizontal and vertical.

Test Plan:
- Reset then pix_ce=1 continuously:
  - vga_hs low for exactly 96 ce cycles per 800.
  - vga_vs low for 2 lines of 525.
  - First HS falling edge 657 ce-edges after release (656 + 1 pipeline).
- Renderer stub returns {x[7:0], y[7:0], 8'hAA, 1}:
  - Pixel (5,3) appears on vga_r/g/b = 05/03/AA exactly one ce after x=5, y=3.
  - vga_de=1 at that output; vga_de=0 and colour 0 at x=640.
- pix_a=0 in the active area with BG_COLOR=24'h102030: output 10/20/30. pix_a=0 in blanking: output 0.
- Run 3 frames:
  - frame_start pulses exactly 3 times, each 1 clk wide; frame_cnt=3.
  - No pulse after reset release.
  - Preload frame_cnt to FFFF via force: next wrap gives 0.
- pix_ce toggling 1-in-2, then held low 100 clks at x=320: no counter or output change. Resumes at x=321.
- Assert rst_n low at (400,200) for 3 clks (async, mid-cycle): outputs go to reset values immediately, and the scan restarts at (0,0).
